// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// It also raises the timer interrupt and commits exception and ERET state.
module cp0_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CODE_ERET    = 32'h0000_000E;

  logic       half;
  logic       is_exc;
  logic       is_eret;
  logic       wr_ok;
  logic [4:0] exccode;

  assign is_eret = (excepttype_i == CODE_ERET);
  assign is_exc  = (excepttype_i != 32'd0) && !is_eret;
  // Any committing exception or ERET squashes a concurrent MTC0.
  assign wr_ok   = we_i && (excepttype_i == 32'd0);
  assign exccode = (excepttype_i == 32'h1) ? 5'd0 : excepttype_i[4:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_o  <= 32'd0;
      count_o     <= 32'd0;
      compare_o   <= 32'd0;
      status_o    <= 32'd0;
      cause_o     <= 32'd0;
      epc_o       <= 32'd0;
      timer_int_o <= 1'b0;
      half        <= 1'b0;
    end else begin
      cause_o[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]};

      if (wr_ok && waddr_i == ADDR_COUNT) begin
        count_o <= wdata_i;
        half    <= 1'b0;
      end else begin
        half <= ~half;
        if (half) count_o <= count_o + 32'd1;
      end

      // A Compare write beats a simultaneous match.
      if (wr_ok && waddr_i == ADDR_COMPARE) begin
        compare_o   <= wdata_i;
        timer_int_o <= 1'b0;
      end else if (compare_o != 32'd0 && count_o == compare_o) begin
        timer_int_o <= 1'b1;
      end

      if (wr_ok) begin
        case (waddr_i)
          ADDR_STATUS: status_o     <= wdata_i & STATUS_WMASK;
          ADDR_CAUSE:  cause_o[9:8] <= wdata_i[9:8];
          ADDR_EPC:    epc_o        <= wdata_i;
          default: ;
        endcase
      end

      if (is_exc) begin
        if (!status_o[1]) begin
          epc_o       <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
          cause_o[31] <= in_delayslot_i;
        end
        status_o[1]   <= 1'b1;
        cause_o[6:2]  <= exccode;
        if (excepttype_i == 32'h4 || excepttype_i == 32'h5)
          badvaddr_o <= bad_addr_i;
      end else if (is_eret) begin
        status_o[1] <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      ADDR_BADVADDR: rdata_o = badvaddr_o;
      ADDR_COUNT:    rdata_o = count_o;
      ADDR_COMPARE:  rdata_o = compare_o;
      ADDR_STATUS:   rdata_o = status_o;
      ADDR_CAUSE:    rdata_o = cause_o;
      ADDR_EPC:      rdata_o = epc_o;
      default:       rdata_o = 32'd0;
    endcase
  end

endmodule
